mux4_rr_arbiter: RTL and testbench
==================================

# mux4_rr_arbiter

Round-robin arbiter that shares one 4:1 single-bit mux between four requesters. It registers a one-hot grant, drives the mux select from that grant, and gates the mux output with a valid flag. A hold limit prevents any single owner from starving the others. It sits in front of the 4:1 select datapath and replaces free-running `sel` stimulus with a request/grant protocol.

## Interface
- `HOLD_MAX`, default 8: max consecutive cycles one owner keeps the grant while others wait. 0 = unlimited; otherwise must be ≥ 2.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset, sampled on `clk` rising edge.
- `req`  in  4  request per requester; bit i = input i (A=0, B=1, C=2, D=3); level-held while using the mux.
- `din`  in  4  mux data inputs: `din[0]`=A, `din[1]`=B, `din[2]`=C, `din[3]`=D.
- `gnt`  out  4  registered one-hot grant, or all-zero.
- `sel`  out  2  registered mux select = index of the granted bit.
- `valid`  out  1  registered; 1 iff `gnt` ≠ 0.
- `y`  out  1  combinational: `din[sel]` when `valid`, else 0.

## Operation
- Reset values: `gnt`=4'b0000, `sel`=2'b00, `valid`=0, `y`=0, hold counter=0, last-grant pointer=3 (requester 0 has highest priority first).
- FSM states:
  - `IDLE`: no grant.
  - `BUSY`: grant held.
- `IDLE`:
  - If any `req` bit is set at an edge: grant the first set bit searching from last+1 modulo 4 → `BUSY`, hold counter=0, last=granted index.
  - Otherwise stay in `IDLE`.
- `BUSY`, evaluated each edge in this order:
  1. Owner's `req` low → release. If any other `req` is set, grant the next in round-robin order in the same edge (no bubble), stay in `BUSY`, counter=0. Otherwise go to `IDLE` with `gnt`=0; `sel` keeps its last value.
  2. Owner's `req` high, `HOLD_MAX`≠0, counter==`HOLD_MAX`-1, and another `req` is set → forced rotation to the next requester, counter=0. The pre-empted owner is not signalled beyond losing `gnt`; it keeps requesting and re-enters the rotation.
  3. Otherwise keep the grant. The counter increments, saturating at `HOLD_MAX`-1. While no one else is waiting, the counter stays saturated and the owner keeps the grant indefinitely.
- Round-robin search: candidates in order last+1, last+2, last+3, last (modulo 4). The first set bit wins.
- Single requester: it is re-granted or kept. No toggling, no bubble.
- `reset` asserted mid-grant: all state returns to reset values on that edge, regardless of `req`.
- `req` bits that change between edges have no effect until sampled.

## Timing
- Grant latency: `req` first seen high at edge N → `gnt`/`sel`/`valid` updated after edge N, visible during cycle N+1.
- Release latency: owner drops `req` before edge N → after edge N the grant is removed or moved to the next requester.
- Maximum continuous ownership under contention: `HOLD_MAX` cycles.
- Worst-case wait for a continuously requesting input with `HOLD_MAX`≠0: 3·`HOLD_MAX` cycles.
- `y` has zero latency from `din` (combinational through the mux) and one cycle from `req`, via registered `sel`/`valid`.

## Structure
- Shared package `mux4_arb_pkg` holds:
  - the state typedef (`IDLE`, `BUSY`);
  - constant `NUM_REQ`=4;
  - the index width (2).
- Sub-module `rr_pick4`: purely combinational. Inputs: 4-bit mask, 2-bit last pointer. Outputs: `found` and a 2-bit index. It is used both for the initial grant and for release/rotation, with the owner's bit masked out for rotation.
- The hold counter width is derived from `HOLD_MAX`.

## Test plan
- Reset with `req`=4'b1111 held → `gnt`=0, `valid`=0, `y`=0 during reset. On the first edge after reset deasserts: `gnt`=4'b0001, `sel`=0.
- `req`=4'b0100, `din`=4'b0100 → one cycle later `gnt`=4'b0100, `sel`=2, `y`=1. Then drop `req` → `valid`=0, `y`=0 the next cycle.
- `req`=4'b1111 held, `HOLD_MAX`=8 → grants 0,1,2,3,0,… each held exactly 8 cycles. `sel` steps 0→1→2→3→0.
- Owner 1 drops `req` while `req`=4'b1001, last=1 → next cycle `gnt`=4'b1000 (no idle cycle between grants).
- Single requester 2 held for 20 cycles with `HOLD_MAX`=4 → `gnt` stays 4'b0100 throughout, no forced release.
- `reset` pulsed during a grant to requester 3 → next cycle `gnt`=0. Then with `req`=4'b1001 → grant goes to 0 (pointer reset to 3).

Source files
------------

// File: rtl/mux4_arb_pkg.sv
// Shared types and constants for the 4-way round-robin mux arbiter.
// Holds the FSM state type, requester count, index width and a one-hot helper.
package mux4_arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_REQ-1:0] onehot;
        onehot      = '0;
        onehot[idx] = 1'b1;
        return onehot;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin search: first set mask bit in order last+1, last+2, last+3, last.
module rr_pick4
    import mux4_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] mask,
    input  logic [IDX_W-1:0]   last,
    output logic               found,
    output logic [IDX_W-1:0]   idx
);

    logic [IDX_W-1:0] cand;

    // Scanning from the lowest priority up lets the highest-priority hit overwrite the rest.
    always_comb begin
        found = 1'b0;
        idx   = last;
        cand  = last;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = last + IDX_W'(k);
            if (mask[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter owning a shared 4:1 single-bit mux, with a hold limit
// that forces rotation when one owner has held the grant too long under contention.
module mux4_rr_arbiter
    import mux4_arb_pkg::*;
#(
    parameter int HOLD_MAX = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] din,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   sel,
    output logic               valid,
    output logic               y
);

    localparam int CNT_W = (HOLD_MAX > 2) ? $clog2(HOLD_MAX) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'((HOLD_MAX > 0) ? HOLD_MAX - 1 : 0);
    localparam bit HOLD_EN = (HOLD_MAX != 0);

    arb_state_t         state, state_n;
    logic [NUM_REQ-1:0] gnt_n;
    logic [IDX_W-1:0]   sel_n;
    logic               valid_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [IDX_W-1:0]   last, last_n;

    logic [NUM_REQ-1:0] pick_mask;
    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;

    // While busy, last always names the owner; masking it out yields "someone else is waiting".
    assign pick_mask = (state == BUSY) ? (req & ~idx_to_onehot(last)) : req;

    rr_pick4 u_pick (
        .mask  (pick_mask),
        .last  (last),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            gnt   <= '0;
            sel   <= '0;
            valid <= 1'b0;
            cnt   <= '0;
            last  <= IDX_W'(NUM_REQ - 1);
        end else begin
            state <= state_n;
            gnt   <= gnt_n;
            sel   <= sel_n;
            valid <= valid_n;
            cnt   <= cnt_n;
            last  <= last_n;
        end
    end

    always_comb begin
        state_n = state;
        gnt_n   = gnt;
        sel_n   = sel;
        valid_n = valid;
        cnt_n   = cnt;
        last_n  = last;

        unique case (state)
            IDLE: begin
                if (pick_found) begin
                    state_n = BUSY;
                    gnt_n   = idx_to_onehot(pick_idx);
                    sel_n   = pick_idx;
                    valid_n = 1'b1;
                    cnt_n   = '0;
                    last_n  = pick_idx;
                end
            end

            BUSY: begin
                if (!req[last]) begin
                    if (pick_found) begin
                        gnt_n  = idx_to_onehot(pick_idx);
                        sel_n  = pick_idx;
                        cnt_n  = '0;
                        last_n = pick_idx;
                    end else begin
                        // sel deliberately keeps the old index; y is gated by valid anyway.
                        state_n = IDLE;
                        gnt_n   = '0;
                        valid_n = 1'b0;
                        cnt_n   = '0;
                    end
                end else if (HOLD_EN && (cnt == CNT_MAX) && pick_found) begin
                    gnt_n  = idx_to_onehot(pick_idx);
                    sel_n  = pick_idx;
                    cnt_n  = '0;
                    last_n = pick_idx;
                end else if (HOLD_EN && (cnt != CNT_MAX)) begin
                    cnt_n = cnt + 1'b1;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign y = valid ? din[sel] : 1'b0;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed self-checking bench for mux4_rr_arbiter (HOLD_MAX=8 and HOLD_MAX=4 instances).
module tb_mux4_rr_arbiter;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic [3:0] din;

    logic [3:0] gnt8, gnt4;
    logic [1:0] sel8, sel4;
    logic       valid8, valid4;
    logic       y8, y4;

    int checkCount;
    int failCount;

    mux4_rr_arbiter #(.HOLD_MAX(8)) u_dut8 (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .din   (din),
        .gnt   (gnt8),
        .sel   (sel8),
        .valid (valid8),
        .y     (y8)
    );

    mux4_rr_arbiter #(.HOLD_MAX(4)) u_dut4 (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .din   (din),
        .gnt   (gnt4),
        .sel   (sel4),
        .valid (valid4),
        .y     (y4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive new inputs, advance one edge, and land 1 time unit after it for sampling.
    task automatic applyStimulus(input logic rst, input logic [3:0] r, input logic [3:0] d);
        reset = rst;
        req   = r;
        din   = d;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] observed, input logic [3:0] expected);
        checkCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    initial begin
        logic [3:0] expGnt;
        logic [1:0] expSel;
        checkCount = 0;
        failCount  = 0;
        reset = 1'b1;
        req   = 4'b1111;
        din   = 4'b1111;

        // Reset held with every requester active
        applyStimulus(1'b1, 4'b1111, 4'b1111);
        applyStimulus(1'b1, 4'b1111, 4'b1111);
        checkOutput("reset_gnt",   gnt8, 4'b0000);
        checkOutput("reset_valid", {3'b0, valid8}, 4'b0000);
        checkOutput("reset_y",     {3'b0, y8}, 4'b0000);
        checkOutput("reset_sel",   {2'b0, sel8}, 4'b0000);
        checkOutput("reset_gnt4",  gnt4, 4'b0000);

        // First edge after reset: requester 0 wins (pointer starts at 3)
        applyStimulus(1'b0, 4'b1111, 4'b1110);
        checkOutput("first_gnt",   gnt8, 4'b0001);
        checkOutput("first_sel",   {2'b0, sel8}, 4'b0000);
        checkOutput("first_valid", {3'b0, valid8}, 4'b0001);
        checkOutput("first_y_lo",  {3'b0, y8}, 4'b0000);
        din = 4'b0001;
        #1;
        checkOutput("first_y_comb", {3'b0, y8}, 4'b0001);

        // Full contention: each owner holds exactly 8 cycles, 0->1->2->3->0
        for (int i = 1; i <= 32; i++) begin
            applyStimulus(1'b0, 4'b1111, 4'b0001);
            expSel = 2'((i / 8) % 4);
            expGnt = 4'b0001 << expSel;
            checkOutput($sformatf("rot_gnt_%0d", i), gnt8, expGnt);
            checkOutput($sformatf("rot_sel_%0d", i), {2'b0, sel8}, {2'b0, expSel});
        end

        // Owner 0 drops, only requester 2 waits: direct handoff
        applyStimulus(1'b0, 4'b0100, 4'b0100);
        checkOutput("r2_gnt", gnt8, 4'b0100);
        checkOutput("r2_sel", {2'b0, sel8}, 4'b0010);
        checkOutput("r2_y",   {3'b0, y8}, 4'b0001);

        // Everyone drops: grant removed, sel keeps 2
        applyStimulus(1'b0, 4'b0000, 4'b0100);
        checkOutput("idle_gnt",   gnt8, 4'b0000);
        checkOutput("idle_valid", {3'b0, valid8}, 4'b0000);
        checkOutput("idle_y",     {3'b0, y8}, 4'b0000);
        checkOutput("idle_sel",   {2'b0, sel8}, 4'b0010);

        // Grant requester 1, then it drops with req=1001: next is 3 with no bubble
        applyStimulus(1'b0, 4'b0010, 4'b0000);
        checkOutput("own1_gnt", gnt8, 4'b0010);
        applyStimulus(1'b0, 4'b1001, 4'b1000);
        checkOutput("hand3_gnt",   gnt8, 4'b1000);
        checkOutput("hand3_sel",   {2'b0, sel8}, 4'b0011);
        checkOutput("hand3_valid", {3'b0, valid8}, 4'b0001);
        checkOutput("hand3_y",     {3'b0, y8}, 4'b0001);

        // Reset mid-grant to 3, then req=1001 goes to 0
        applyStimulus(1'b1, 4'b1001, 4'b1000);
        checkOutput("midrst_gnt", gnt8, 4'b0000);
        checkOutput("midrst_sel", {2'b0, sel8}, 4'b0000);
        applyStimulus(1'b0, 4'b1001, 4'b1000);
        checkOutput("postrst_gnt", gnt8, 4'b0001);
        checkOutput("postrst_sel", {2'b0, sel8}, 4'b0000);

        // Single requester 2 for 20 cycles on HOLD_MAX=4: never released
        applyStimulus(1'b1, 4'b0000, 4'b0000);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 4'b0100, 4'b0000);
            checkOutput($sformatf("single_gnt4_%0d", i), gnt4, 4'b0100);
        end

        // Saturated owner 2 gets rotated away on the very next contended edge
        applyStimulus(1'b0, 4'b0110, 4'b0000);
        checkOutput("sat_rot_gnt4", gnt4, 4'b0010);
        checkOutput("sat_rot_gnt8", gnt8, 4'b0010);
        applyStimulus(1'b0, 4'b0110, 4'b0000);
        checkOutput("sat_hold_gnt4", gnt4, 4'b0010);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
